// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues one outstanding imem request at a time and buffers
// responses in a 2-entry in-order queue that feeds the IF/ID register.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] PC_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        flush_o,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc_q;
    logic [31:0] req_pc;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic [1:0]  count;
    logic        pop;
    logic        push;
    logic        grant;
    logic        req;

    // Handshake: imem_req_o/imem_addr_o hold until imem_req_o && imem_gnt_i at a rising
    // edge (only a redirect may withdraw them); imem_rvalid_i returns data in order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A response arriving in WAIT or DROP always retires the outstanding request,
    // even in a redirect cycle; only the redirect decides whether it is kept.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (grant) state_next = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid_i)  state_next = S_IDLE;
                else if (branch_i)  state_next = S_DROP;
            end
            S_DROP:  if (imem_rvalid_i) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        pop         = (count != 2'd0) && !Stall_i && !branch_i && !rst_i;
        req         = !rst_i && (state == S_IDLE) && !branch_i
                      && ((count - {1'b0, pop}) < 2'd2);
        grant       = req && imem_gnt_i;
        push        = (state == S_WAIT) && imem_rvalid_i && !branch_i && !rst_i;
        imem_req_o  = req;
        imem_addr_o = pc_q;
        valid_o     = !rst_i && (count != 2'd0);
        PC_o        = valid_o ? q_pc[0] : 32'h0000_0000;
        instr_o     = valid_o ? q_instr[0] : NOP_INSTR;
        flush_o     = branch_i;
        fsm_state   = state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q  <= RESET_PC;
            count <= 2'd0;
        end else if (branch_i) begin
            pc_q  <= branch_target_i & ~32'd3;
            count <= 2'd0;
        end else begin
            if (grant) begin
                pc_q   <= pc_q + 32'd4;
                req_pc <= pc_q;
            end
            case ({push, pop})
                2'b10: begin
                    q_pc[count[0]]    <= req_pc;
                    q_instr[count[0]] <= imem_rdata_i;
                    count             <= count + 2'd1;
                end
                2'b01: begin
                    q_pc[0]    <= q_pc[1];
                    q_instr[0] <= q_instr[1];
                    count      <= count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind whatever survives the pop.
                    if (count == 2'd2) begin
                        q_pc[0]    <= q_pc[1];
                        q_instr[0] <= q_instr[1];
                        q_pc[1]    <= req_pc;
                        q_instr[1] <= imem_rdata_i;
                    end else begin
                        q_pc[0]    <= req_pc;
                        q_instr[0] <= imem_rdata_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a queue-based fetch model checked every cycle,
// plus literal expectations for reset, streaming, stall, redirect, wrap and mid-reset.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [31:0] target = 32'h0;
    logic        gnt = 1'b1;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;

    logic        req, valid, flush;
    logic [31:0] addr, pc, instr;
    logic [1:0]  state;
    logic        w_req, w_valid, w_flush;
    logic [31:0] w_addr, w_pc, w_instr;
    logic [1:0]  w_state;

    always #5 clk = ~clk;

    instr_fetch u_dut (
        .clk_i(clk), .rst_i(rst), .Stall_i(stall), .branch_i(branch),
        .branch_target_i(target), .imem_req_o(req), .imem_addr_o(addr),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .PC_o(pc), .instr_o(instr), .valid_o(valid), .flush_o(flush),
        .fsm_state(state)
    );

    instr_fetch #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_wrap (
        .clk_i(clk), .rst_i(rst), .Stall_i(stall), .branch_i(branch),
        .branch_target_i(target), .imem_req_o(w_req), .imem_addr_o(w_addr),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .PC_o(w_pc), .instr_o(w_instr), .valid_o(w_valid), .flush_o(w_flush),
        .fsm_state(w_state)
    );

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: answers each grant in order, mem_lat cycles later than minimum.
    logic [31:0] mem_pend[$];
    int          mem_due[$];
    int          cyc = 0;
    int          mem_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #3;
        if (!rst && req && gnt) begin
            mem_pend.push_back(addr);
            mem_due.push_back(cyc + 1 + mem_lat);
        end
    end

    task automatic tick(input logic r, input logic s, input logic b,
                        input logic [31:0] t, input logic g);
        @(negedge clk);
        rst = r; stall = s; branch = b; target = t; gnt = g;
        rvalid = 1'b0;
        rdata = $urandom;
        if (r) begin
            mem_pend.delete();
            mem_due.delete();
        end else if (mem_pend.size() > 0 && cyc >= mem_due[0]) begin
            rvalid = 1'b1;
            rdata = mem_fn(mem_pend.pop_front());
            void'(mem_due.pop_front());
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic wait_req(input int max, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            #3;
            seen = (req === 1'b1);
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic wait_valid(input int max, input string nm);
        bit seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            #3;
            seen = (valid === 1'b1);
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    // Behavioural model: fetch queue of PCs, next-fetch PC, one outstanding request.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_q[$];
    bit          m_out = 1'b0;
    bit          m_keep = 1'b0;
    logic [31:0] m_out_pc = 32'h0;
    logic [31:0] got_q[$];
    bit          e_valid, e_pop, e_req;
    logic [31:0] e_pc, e_instr;

    always @(negedge clk) begin
        #2;
        e_valid = !rst && (m_q.size() > 0);
        e_pc    = e_valid ? m_q[0] : 32'h0;
        e_instr = e_valid ? mem_fn(m_q[0]) : 32'h0;
        e_pop   = e_valid && !stall && !branch;
        e_req   = !rst && !m_out && !branch && ((m_q.size() - (e_pop ? 1 : 0)) < 2);
        chk("req", 32'(req), 32'(e_req));
        chk("valid", 32'(valid), 32'(e_valid));
        chk("pc", pc, e_pc);
        chk("instr", instr, e_instr);
        chk("flush", 32'(flush), 32'(branch));
        if (!rst) chk("addr", addr, m_pc);
        if (!rst && valid && !stall && !branch) got_q.push_back(pc);

        if (rst) begin
            m_pc = 32'h0;
            m_q.delete();
            m_out = 1'b0;
        end else if (branch) begin
            m_q.delete();
            m_pc = target & ~32'd3;
            if (m_out && rvalid) m_out = 1'b0;
            else m_keep = 1'b0;
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_out && rvalid) begin
                if (m_keep) m_q.push_back(m_out_pc);
                m_out = 1'b0;
            end
            if (e_req && gnt) begin
                m_out = 1'b1;
                m_keep = 1'b1;
                m_out_pc = m_pc;
                m_pc = m_pc + 32'd4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset: outputs idle, parameters visible on both instances.
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_wrap_instr", w_instr, 32'h0000_0013);
        chk("rst_wrap_valid", 32'(w_valid), 32'd0);
        chk("rst_wrap_pc", w_pc, 32'h0);
        chk("rst_wrap_req", 32'(w_req), 32'd0);
        chk("rst_wrap_flush", 32'(w_flush), 32'd0);
        chk("rst_wrap_state", 32'(w_state), 32'd0);

        // Streaming, grant gaps, then 5-cycle stall and release.
        got_q.delete();
        idle(1);
        #3;
        chk("first_req", 32'(req), 32'd1);
        chk("first_addr", addr, 32'h0);
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        idle(2);
        #3;
        chk("second_addr", addr, 32'h4);
        chk("wrap_second_req", 32'(w_req), 32'd1);
        chk("wrap_second_addr", w_addr, 32'h0);
        idle(10);
        repeat (4) tick(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(4);
        repeat (5) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        #3;
        chk("stall_full_valid", 32'(valid), 32'd1);
        chk("stall_full_req", 32'(req), 32'd0);
        idle(10);
        chk("stream_count", 32'(got_q.size() >= 8), 32'd1);
        for (int i = 0; i < got_q.size(); i++) chk("stream_pc", got_q[i], 32'(i * 4));

        // Redirect while a request is outstanding.
        mem_lat = 2;
        wait_req(20, "redir_wait_req");
        tick(1'b0, 1'b0, 1'b1, 32'h0000_0103, 1'b1);
        #3;
        chk("redir_flush", 32'(flush), 32'd1);
        chk("redir_req", 32'(req), 32'd0);
        idle(1);
        #3;
        chk("redir_valid", 32'(valid), 32'd0);
        chk("redir_drop_req", 32'(req), 32'd0);
        chk("redir_state_drop", 32'(state), 32'd2);
        wait_req(10, "redir_next_req");
        chk("redir_addr", addr, 32'h0000_0100);
        wait_valid(10, "redir_next_valid");
        chk("redir_pc", pc, 32'h0000_0100);
        chk("redir_instr", instr, 32'h1357_9ADF);

        // Redirect coincident with a response while stalled.
        mem_lat = 0;
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        repeat (3) tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        #3;
        chk("coinc_rvalid", 32'(rvalid), 32'd1);
        chk("coinc_valid", 32'(valid), 32'd1);
        chk("coinc_head_pc", pc, 32'h0);
        tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        #3;
        chk("coinc_after_valid", 32'(valid), 32'd0);
        wait_valid(10, "coinc_next_valid");
        chk("coinc_pc", pc, 32'h0000_0200);
        chk("coinc_instr", instr, 32'h1357_99DF);

        // Reset in the middle of an outstanding request.
        mem_lat = 2;
        wait_req(10, "midrst_wait_req");
        tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        #3;
        chk("midrst_valid", 32'(valid), 32'd0);
        chk("midrst_req", 32'(req), 32'd0);
        idle(1);
        #3;
        chk("midrst_next_req", 32'(req), 32'd1);
        chk("midrst_next_addr", addr, 32'h0);
        chk("midrst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        wait_valid(10, "midrst_next_valid");
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_instr", instr, 32'h1357_9BDF);
        idle(4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
